mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and shared memory port.
// slave is the arbiter's view; master is the environment (requesters + memory).
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Fetch requester (read only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // Data requester (loads and stores)
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // Shared single-port memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch + data) in front of one single-port memory.
// Grants are combinational; read data is routed back through an owner-tag
// pipeline MEM_LAT deep, so responses return in issue order.
// Optional feature: define MEM_ARB_RR_EN for round-robin contention handling;
// otherwise data always beats fetch.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1   // legal 1..4
) (
    input logic        clk,
    input logic        reset,  // synchronous, active low
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagIf   = 2'd1,
        TagD    = 2'd2
    } tag_e;

    logic gnt_if;
    logic gnt_d;
    tag_e push_tag;
    tag_e tag_q [MEM_LAT];
    tag_e tag_out;

`ifdef MEM_ARB_RR_EN
    logic prio_d_q;  // 1: data wins next contention, 0: fetch wins
`endif

    // Grant decision; everything is held off while reset is asserted
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (reset) begin
`ifdef MEM_ARB_RR_EN
            if (bus.d_req && bus.if_req) begin
                gnt_d  = prio_d_q;
                gnt_if = ~prio_d_q;
            end else begin
                gnt_d  = bus.d_req;
                gnt_if = bus.if_req;
            end
`else
            gnt_d  = bus.d_req;
            gnt_if = bus.if_req & ~bus.d_req;
`endif
        end
    end

    // Memory strobe and payload mux; payload is zero when nobody is granted
    always_comb begin
        bus.if_gnt    = gnt_if;
        bus.d_gnt     = gnt_d;
        bus.mem_en    = gnt_if | gnt_d;
        bus.mem_we    = gnt_d & bus.d_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (gnt_if) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    // Tag pushed this cycle: owner of a read, NONE for a store or idle cycle
    always_comb begin
        push_tag = TagNone;
        if (gnt_d && !bus.d_we) begin
            push_tag = TagD;
        end else if (gnt_if) begin
            push_tag = TagIf;
        end
    end

    // Owner-tag shift register; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= TagNone;
            end
        end else begin
            tag_q[0] <= push_tag;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[MEM_LAT-1];

    // Response steering; forced quiet while reset is asserted
    always_comb begin
        bus.if_rvalid = reset && (tag_out == TagIf);
        bus.d_rvalid  = reset && (tag_out == TagD);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
    end

`ifdef MEM_ARB_RR_EN
    // After a contended grant the loser gets priority; lone requests leave it alone
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_d_q <= 1'b1;
        end else if (bus.d_req && bus.if_req) begin
            prio_d_q <= gnt_if;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// The memory model returns addr ^ 0x5A5A0000 exactly MEM_LAT cycles after the strobe.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: address pipelines of depth 1 and 3
    logic [31:0] p1;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        p1    <= b1.mem_addr;
        p3[0] <= b3.mem_addr;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign b1.mem_rdata = p1 ^ 32'h5A5A_0000;
    assign b3.mem_rdata = p3[2] ^ 32'h5A5A_0000;

    // Alternating IF/D read table for the MEM_LAT=3 instance
    // req: {d, if}; rv: expected {d_rvalid, if_rvalid}; dat: expected rdata of the valid one
    logic [1:0]  req41 [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [31:0] adr41 [8] = '{32'h10, 32'h200, 32'h14, 32'h204, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [1:0]  rv41  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [31:0] dat41 [8] = '{32'h0, 32'h0, 32'h0, 32'h5A5A_0010, 32'h5A5A_0200,
                               32'h5A5A_0014, 32'h5A5A_0204, 32'h0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        b1.if_req = 1'b0; b1.if_addr = '0;
        b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0;
        b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle_all();

        // Reset: requests are ignored and outputs stay at zero
        tick();
        b1.if_req = 1'b1; b1.if_addr = 32'h70;
        b1.d_req  = 1'b1; b1.d_addr  = 32'h74;
        b3.if_req = 1'b1; b3.if_addr = 32'h78;
        @(negedge clk);
        check("rst_if_gnt",    b1.if_gnt,    0);
        check("rst_d_gnt",     b1.d_gnt,     0);
        check("rst_mem_en",    b1.mem_en,    0);
        check("rst_mem_addr",  b1.mem_addr,  0);
        check("rst_if_rvalid", b1.if_rvalid, 0);
        check("rst_d_rdata",   b1.d_rdata,   0);
        check("rst3_mem_en",   b3.mem_en,    0);

        // Fetch stream 0x0, 0x4, 0x8 at MEM_LAT=1
        tick();
        idle_all();
        reset = 1'b1;
        b1.if_req = 1'b1; b1.if_addr = 32'h0;
        @(negedge clk);
        check("f0_if_gnt",    b1.if_gnt,    1);
        check("f0_mem_en",    b1.mem_en,    1);
        check("f0_mem_we",    b1.mem_we,    0);
        check("f0_mem_addr",  b1.mem_addr,  32'h0);
        check("f0_if_rvalid", b1.if_rvalid, 0);
        tick();
        b1.if_addr = 32'h4;
        @(negedge clk);
        check("f1_if_gnt",    b1.if_gnt,    1);
        check("f1_mem_addr",  b1.mem_addr,  32'h4);
        check("f1_if_rvalid", b1.if_rvalid, 1);
        check("f1_if_rdata",  b1.if_rdata,  32'h5A5A_0000);
        tick();
        b1.if_addr = 32'h8;
        @(negedge clk);
        check("f2_if_gnt",    b1.if_gnt,    1);
        check("f2_if_rvalid", b1.if_rvalid, 1);
        check("f2_if_rdata",  b1.if_rdata,  32'h5A5A_0004);
        tick();
        b1.if_req = 1'b0; b1.if_addr = 32'h0;
        @(negedge clk);
        check("f3_if_gnt",    b1.if_gnt,    0);
        check("f3_mem_en",    b1.mem_en,    0);
        check("f3_if_rvalid", b1.if_rvalid, 1);
        check("f3_if_rdata",  b1.if_rdata,  32'h5A5A_0008);
        tick();
        @(negedge clk);
        check("f4_if_rvalid", b1.if_rvalid, 0);
        check("f4_if_rdata",  b1.if_rdata,  0);

        // Contention: data load wins, fetch follows, responses in issue order
        tick();
        b1.if_req = 1'b1; b1.if_addr = 32'h40;
        b1.d_req  = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h100;
        @(negedge clk);
        check("c0_d_gnt",     b1.d_gnt,    1);
        check("c0_if_gnt",    b1.if_gnt,   0);
        check("c0_mem_addr",  b1.mem_addr, 32'h100);
        check("c0_mem_we",    b1.mem_we,   0);
        tick();
        b1.d_req = 1'b0; b1.d_addr = '0;
        @(negedge clk);
        check("c1_if_gnt",    b1.if_gnt,    1);
        check("c1_mem_addr",  b1.mem_addr,  32'h40);
        check("c1_d_rvalid",  b1.d_rvalid,  1);
        check("c1_d_rdata",   b1.d_rdata,   32'h5A5A_0100);
        check("c1_if_rvalid", b1.if_rvalid, 0);
        tick();
        b1.if_req = 1'b0; b1.if_addr = '0;
        @(negedge clk);
        check("c2_if_rvalid", b1.if_rvalid, 1);
        check("c2_if_rdata",  b1.if_rdata,  32'h5A5A_0040);
        check("c2_d_rvalid",  b1.d_rvalid,  0);

        // Store: strobes and payload, no response afterwards
        tick();
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h20; b1.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("st_d_gnt",     b1.d_gnt,     1);
        check("st_if_gnt",    b1.if_gnt,    0);
        check("st_mem_en",    b1.mem_en,    1);
        check("st_mem_we",    b1.mem_we,    1);
        check("st_mem_addr",  b1.mem_addr,  32'h20);
        check("st_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
        tick();
        idle_all();
        @(negedge clk);
        check("st1_d_rvalid",  b1.d_rvalid,  0);
        check("st1_mem_we",    b1.mem_we,    0);
        check("st1_mem_wdata", b1.mem_wdata, 0);
        tick();
        @(negedge clk);
        check("st2_d_rvalid",  b1.d_rvalid,  0);

        // Alternating IF/D reads at MEM_LAT=3
        for (int k = 0; k < 8; k++) begin
            tick();
            b3.if_req = req41[k][0];
            b3.d_req  = req41[k][1];
            b3.d_we   = 1'b0;
            b3.if_addr = req41[k][0] ? adr41[k] : 32'h0;
            b3.d_addr  = req41[k][1] ? adr41[k] : 32'h0;
            @(negedge clk);
            check($sformatf("l3_c%0d_if_gnt", k),    b3.if_gnt,    req41[k][0]);
            check($sformatf("l3_c%0d_d_gnt", k),     b3.d_gnt,     req41[k][1]);
            check($sformatf("l3_c%0d_if_rvalid", k), b3.if_rvalid, rv41[k][0]);
            check($sformatf("l3_c%0d_d_rvalid", k),  b3.d_rvalid,  rv41[k][1]);
            check($sformatf("l3_c%0d_if_rdata", k),  b3.if_rdata,  rv41[k][0] ? dat41[k] : 32'h0);
            check($sformatf("l3_c%0d_d_rdata", k),   b3.d_rdata,   rv41[k][1] ? dat41[k] : 32'h0);
        end

        // Reset with reads in flight: nothing comes back after release
        tick();
        idle_all();
        b1.if_req = 1'b1; b1.if_addr = 32'h30;
        b3.d_req  = 1'b1; b3.d_addr  = 32'h300;
        @(negedge clk);
        check("rf_if_gnt1", b1.if_gnt, 1);
        check("rf_d_gnt3",  b3.d_gnt,  1);
        tick();
        reset = 1'b0;
        idle_all();
        b3.if_req = 1'b1; b3.if_addr = 32'h34;
        @(negedge clk);
        check("rf_rst_if_rvalid1", b1.if_rvalid, 0);
        check("rf_rst_if_rdata1",  b1.if_rdata,  0);
        check("rf_rst_if_gnt3",    b3.if_gnt,    0);
        check("rf_rst_mem_en3",    b3.mem_en,    0);
        check("rf_rst_mem_addr3",  b3.mem_addr,  0);
        tick();
        reset = 1'b1;
        b3.if_req = 1'b0; b3.if_addr = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rf_post%0d_if_rvalid1", k), b1.if_rvalid, 0);
            check($sformatf("rf_post%0d_d_rvalid3", k),  b3.d_rvalid,  0);
            check($sformatf("rf_post%0d_d_rdata3", k),   b3.d_rdata,   0);
            tick();
        end

        // Both requesters held for four cycles, right after reset (pointer at D)
        b1.if_req = 1'b1; b1.if_addr = 32'h50;
        b1.d_req  = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h60;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            @(negedge clk);
            check($sformatf("hold%0d_d_gnt", k),    b1.d_gnt,    exp_d);
            check($sformatf("hold%0d_if_gnt", k),   b1.if_gnt,   !exp_d);
            check($sformatf("hold%0d_mem_addr", k), b1.mem_addr, exp_d ? 32'h60 : 32'h50);
            tick();
        end
        idle_all();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
